uart_frame_decoder: RTL and testbench

- Consumes received characters from the UART receive FIFO and parses framed register-write commands: SYNC 0xA5, ADDR, LEN, LEN payload bytes, CHK.
- Payload is buffered internally until the checksum is verified; only then are writes issued on a register-write handshake.
- Sits directly downstream of the buffered UART read port, between it and the control register bank.

---
 rtl/uart_frame_decoder.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_frame_decoder.sv | 515 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_decoder.sv
// Frame decoder between the UART receive FIFO and the control register bank.
// Parses A5/ADDR/LEN/payload/CHK frames and replays the payload as writes once CHK matches.
module uart_frame_decoder #(
    parameter int MAX_LEN       = 16,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     empty_i,
    output logic                     readReq_o,
    input  logic                     readAck_i,
    input  logic [10:0]              dataIn_i,
    input  logic [TIMEOUT_WIDTH-1:0] timeoutCycles_i,
    output logic                     regWriteReq_o,
    input  logic                     regWriteAck_i,
    output logic [7:0]               regAddr_o,
    output logic [7:0]               regData_o,
    output logic                     busy_o,
    output logic                     frameOk_o,
    output logic                     frameErr_o,
    output logic [2:0]               errCode_o,
    output logic [7:0]               errCount_o,
    output logic [2:0]               state_o
);

    localparam int IDX_W = $clog2(MAX_LEN + 1);
    localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [2:0] ERR_LEN     = 3'd1;
    localparam logic [2:0] ERR_CHK     = 3'd2;
    localparam logic [2:0] ERR_LINE    = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;

    typedef enum logic [2:0] {
        S_HUNT    = 3'd0,
        S_ADDR    = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CHECK   = 3'd4,
        S_EMIT    = 3'd5
    } state_e;

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [IDX_W-1:0]         len_q, len_d;
    logic [7:0]               base_q, base_d;
    logic [7:0]               chk_q, chk_d;
    logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
    logic                     frame_ok_q, frame_ok_d;
    logic                     frame_err_q;
    logic [2:0]               err_code_q;
    logic [7:0]               err_count_q;
    logic [7:0]               buf_q [MAX_LEN];

    logic       buf_we;
    logic       consume;
    logic       line_err;
    logic       rx_state;
    logic       tmo_en;
    logic       tmo_fire;
    logic       last_write;
    logic       reject;
    logic [2:0] rej_code;
    logic [7:0] rx_byte;

    assign rx_byte    = dataIn_i[7:0];
    assign line_err   = dataIn_i[10] | dataIn_i[9];
    assign consume    = readAck_i && (state_q != S_EMIT);
    assign rx_state   = (state_q == S_ADDR) || (state_q == S_LEN) ||
                        (state_q == S_PAYLOAD) || (state_q == S_CHECK);
    assign tmo_en     = rx_state && (timeoutCycles_i != '0);
    // A character arriving in the firing cycle wins over the timeout.
    assign tmo_fire   = tmo_en && !consume &&
                        (tmo_q == timeoutCycles_i - TIMEOUT_WIDTH'(1));
    assign last_write = (idx_q + IDX_W'(1)) == len_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        base_d     = base_q;
        chk_d      = chk_q;
        buf_we     = 1'b0;
        frame_ok_d = 1'b0;
        reject     = 1'b0;
        rej_code   = ERR_LEN;

        case (state_q)
            S_HUNT: begin
                if (consume && !line_err && rx_byte == SYNC_BYTE) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (consume) begin
                    if (line_err) begin
                        reject   = 1'b1;
                        rej_code = ERR_LINE;
                    end else begin
                        base_d  = rx_byte;
                        chk_d   = rx_byte;
                        state_d = S_LEN;
                    end
                end
            end
            S_LEN: begin
                if (consume) begin
                    if (line_err) begin
                        reject   = 1'b1;
                        rej_code = ERR_LINE;
                    end else if (rx_byte == 8'h00 || rx_byte > MAX_LEN_B) begin
                        reject   = 1'b1;
                        rej_code = ERR_LEN;
                    end else begin
                        len_d   = IDX_W'(rx_byte);
                        chk_d   = chk_q ^ rx_byte;
                        idx_d   = '0;
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                // 0xA5 here is ordinary data; resync only happens from HUNT.
                if (consume) begin
                    if (line_err) begin
                        reject   = 1'b1;
                        rej_code = ERR_LINE;
                    end else begin
                        buf_we = 1'b1;
                        chk_d  = chk_q ^ rx_byte;
                        idx_d  = idx_q + IDX_W'(1);
                        if (last_write) begin
                            state_d = S_CHECK;
                        end
                    end
                end
            end
            S_CHECK: begin
                if (consume) begin
                    if (line_err) begin
                        reject   = 1'b1;
                        rej_code = ERR_LINE;
                    end else if (rx_byte == chk_q) begin
                        idx_d   = '0;
                        state_d = S_EMIT;
                    end else begin
                        reject   = 1'b1;
                        rej_code = ERR_CHK;
                    end
                end
            end
            S_EMIT: begin
                if (regWriteAck_i) begin
                    if (last_write) begin
                        frame_ok_d = 1'b1;
                        state_d    = S_HUNT;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = S_HUNT;
        endcase

        if (tmo_fire) begin
            reject   = 1'b1;
            rej_code = ERR_TIMEOUT;
        end
        if (reject) begin
            state_d = S_HUNT;
        end
    end

    // Counter restarts on every consumed character and on every state change.
    always_comb begin
        tmo_d = '0;
        if (tmo_en && !consume && state_d == state_q) begin
            tmo_d = tmo_q + TIMEOUT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_HUNT;
            idx_q       <= '0;
            len_q       <= '0;
            base_q      <= '0;
            chk_q       <= '0;
            tmo_q       <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            base_q      <= base_d;
            chk_q       <= chk_d;
            tmo_q       <= tmo_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= reject;
            if (reject) begin
                err_code_q <= rej_code;
                if (err_count_q != 8'hFF) begin
                    err_count_q <= err_count_q + 8'd1;
                end
            end
        end
    end

    // Payload storage carries no reset; it is always refilled before EMIT reads it.
    always_ff @(posedge clk_i) begin
        if (buf_we) begin
            buf_q[idx_q[PTR_W-1:0]] <= rx_byte;
        end
    end

    assign readReq_o     = !empty_i && (state_q != S_EMIT);
    assign regWriteReq_o = (state_q == S_EMIT);
    assign regAddr_o     = regWriteReq_o ? (base_q + 8'(idx_q)) : 8'h00;
    assign regData_o     = regWriteReq_o ? buf_q[idx_q[PTR_W-1:0]] : 8'h00;
    assign busy_o        = (state_q != S_HUNT);
    assign frameOk_o     = frame_ok_q;
    assign frameErr_o    = frame_err_q;
    assign errCode_o     = err_code_q;
    assign errCount_o    = err_count_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder: FIFO driver, delayed-ack register responder,
// and per-scenario tasks that compare against hand-computed writes and error codes.
module tb_uart_frame_decoder;

  localparam int MAX_LEN = 16;
  localparam int TW      = 16;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          empty      = 1'b1;
  logic          read_ack   = 1'b0;
  logic [10:0]   data_in    = '0;
  logic [TW-1:0] tmo_cycles = '0;
  logic          wr_ack     = 1'b0;
  logic          read_req;
  logic          wr_req;
  logic [7:0]    wr_addr;
  logic [7:0]    wr_data;
  logic          busy;
  logic          frame_ok;
  logic          frame_err;
  logic [2:0]    err_code;
  logic [7:0]    err_count;
  logic [2:0]    state;

  uart_frame_decoder #(.MAX_LEN(MAX_LEN), .TIMEOUT_WIDTH(TW)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .empty_i         (empty),
    .readReq_o       (read_req),
    .readAck_i       (read_ack),
    .dataIn_i        (data_in),
    .timeoutCycles_i (tmo_cycles),
    .regWriteReq_o   (wr_req),
    .regWriteAck_i   (wr_ack),
    .regAddr_o       (wr_addr),
    .regData_o       (wr_data),
    .busy_o          (busy),
    .frameOk_o       (frame_ok),
    .frameErr_o      (frame_err),
    .errCode_o       (err_code),
    .errCount_o      (err_count),
    .state_o         (state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ok_pulses = 0;
  int err_pulses = 0;
  int req_cycles = 0;
  int ack_delay = 0;
  int wcnt = 0;
  int exp_err_count = 0;
  logic [7:0]  h_addr, h_data;
  logic [15:0] exp_q[$];
  logic [15:0] wr_q[$];
  logic [7:0]  tx_q[$];

  // Register-bank responder and pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (frame_ok === 1'b1) ok_pulses++;
    if (frame_err === 1'b1) err_pulses++;
    if (wr_req === 1'b1) req_cycles++;
    if (rst || wr_ack) begin
      wr_ack = 1'b0;
      wcnt = 0;
    end else if (wr_req === 1'b1) begin
      if (wcnt == 0) begin
        h_addr = wr_addr;
        h_data = wr_data;
      end else begin
        checks++;
        if (wr_addr !== h_addr || wr_data !== h_data) begin
          errors++;
          $display("FAIL write_hold: addr/data %h/%h, required %h/%h", wr_addr, wr_data, h_addr, h_data);
        end
      end
      if (empty == 1'b0) begin
        checks++;
        if (read_req !== 1'b0) begin
          errors++;
          $display("FAIL readreq_emit: readReq=%b, required 0", read_req);
        end
      end
      if (wcnt >= ack_delay) begin
        wr_ack = 1'b1;
        wr_q.push_back({wr_addr, wr_data});
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic send_char(input logic [10:0] c);
    int n;
    n = 0;
    empty = 1'b0;
    #1;
    while (read_req !== 1'b1 && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (read_req !== 1'b1) begin
      errors++;
      $display("FAIL send_char: readReq=%b after %0d cycles, required 1 (char %h)", read_req, n, c);
      empty = 1'b1;
    end else begin
      read_ack = 1'b1;
      data_in = c;
      @(negedge clk);
      read_ack = 1'b0;
      empty = 1'b1;
    end
  endtask

  task automatic send_tx();
    foreach (tx_q[i]) send_char({3'b000, tx_q[i]});
    tx_q.delete();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    empty = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b state=%0d, required 0/0", busy, state);
    end
    checks++;
    if ({read_req, wr_req, frame_ok, frame_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: req/wreq/ok/err=%b, required 0000", {read_req, wr_req, frame_ok, frame_err});
    end
    checks++;
    if ({wr_addr, wr_data} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_bus: addr/data=%h/%h, required 00/00", wr_addr, wr_data);
    end
    checks++;
    if (err_code !== 3'd0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_err: code=%0d count=%0d, required 0/0", err_code, err_count);
    end
    rst = 1'b0;
    exp_err_count = 0;
    @(negedge clk);
    empty = 1'b0;
    #1;
    checks++;
    if (read_req !== 1'b1) begin
      errors++;
      $display("FAIL readreq_hunt: readReq=%b with data waiting, required 1", read_req);
    end
    empty = 1'b1;
    #1;
    checks++;
    if (read_req !== 1'b0) begin
      errors++;
      $display("FAIL readreq_empty: readReq=%b with FIFO empty, required 0", read_req);
    end
    @(negedge clk);
  endtask

  task automatic test_good_frame();
    int ok0, err0;
    ok0 = ok_pulses;
    err0 = err_pulses;
    wr_q.delete();
    exp_q = '{16'h1011, 16'h1122};
    tx_q = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
    send_tx();
    wait_idle();
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL good_count: %0d writes, required %0d", wr_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (wr_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL good_write%0d: addr/data %h, required %h", i, wr_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (ok_pulses - ok0 != 1 || err_pulses != err0) begin
      errors++;
      $display("FAIL good_pulses: ok=%0d err=%0d, required 1/0", ok_pulses - ok0, err_pulses - err0);
    end
    checks++;
    if (err_count !== 8'(exp_err_count)) begin
      errors++;
      $display("FAIL good_errcount: %0d, required %0d", err_count, exp_err_count);
    end
  endtask

  task automatic test_bad_checksum();
    int ok0, err0, req0;
    ok0 = ok_pulses;
    err0 = err_pulses;
    req0 = req_cycles;
    wr_q.delete();
    tx_q = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h20};
    send_tx();
    wait_idle();
    exp_err_count++;
    checks++;
    if (req_cycles != req0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL chk_nowrite: %0d req cycles, %0d writes, required 0/0", req_cycles - req0, wr_q.size());
    end
    checks++;
    if (err_pulses - err0 != 1 || ok_pulses != ok0) begin
      errors++;
      $display("FAIL chk_pulses: err=%0d ok=%0d, required 1/0", err_pulses - err0, ok_pulses - ok0);
    end
    checks++;
    if (err_code !== 3'd2 || err_count !== 8'(exp_err_count)) begin
      errors++;
      $display("FAIL chk_code: code=%0d count=%0d, required 2/%0d", err_code, err_count, exp_err_count);
    end
  endtask

  task automatic test_noise_wrap_stall();
    int ok0;
    ok0 = ok_pulses;
    wr_q.delete();
    ack_delay = 3;
    exp_q = '{16'hFFAA, 16'h00BB};
    tx_q = '{8'h00, 8'h13, 8'hA5, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'hEC};
    send_tx();
    empty = 1'b0;
    wait_idle();
    empty = 1'b1;
    ack_delay = 0;
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL wrap_count: %0d writes, required %0d", wr_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (wr_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL wrap_write%0d: addr/data %h, required %h", i, wr_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (ok_pulses - ok0 != 1) begin
      errors++;
      $display("FAIL wrap_ok: %0d pulse cycles, required 1", ok_pulses - ok0);
    end
  endtask

  task automatic test_len_limits();
    int err0, ok0;
    err0 = err_pulses;
    tx_q = '{8'hA5, 8'h00, 8'h00};
    send_tx();
    wait_idle();
    exp_err_count++;
    checks++;
    if (err_code !== 3'd1 || err_pulses - err0 != 1) begin
      errors++;
      $display("FAIL len_zero: code=%0d pulses=%0d, required 1/1", err_code, err_pulses - err0);
    end
    err0 = err_pulses;
    tx_q = '{8'hA5, 8'h00, 8'h11};
    send_tx();
    wait_idle();
    exp_err_count++;
    checks++;
    if (err_code !== 3'd1 || err_pulses - err0 != 1 || err_count !== 8'(exp_err_count)) begin
      errors++;
      $display("FAIL len_over: code=%0d pulses=%0d count=%0d, required 1/1/%0d",
               err_code, err_pulses - err0, err_count, exp_err_count);
    end
    // Largest legal frame: payload 00..0F XORs to zero, so CHK = 70 ^ 10.
    ok0 = ok_pulses;
    wr_q.delete();
    exp_q.delete();
    tx_q = '{8'hA5, 8'h70, 8'h10};
    for (int i = 0; i < MAX_LEN; i++) begin
      tx_q.push_back(8'(i));
      exp_q.push_back({8'(8'h70 + i), 8'(i)});
    end
    tx_q.push_back(8'h60);
    send_tx();
    wait_idle();
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL len_max_count: %0d writes, required %0d", wr_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (wr_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL len_max_write%0d: addr/data %h, required %h", i, wr_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (ok_pulses - ok0 != 1) begin
      errors++;
      $display("FAIL len_max_ok: %0d pulse cycles, required 1", ok_pulses - ok0);
    end
  endtask

  task automatic test_timeout();
    int k, err0;
    err0 = err_pulses;
    tmo_cycles = 16'd100;
    tx_q = '{8'hA5, 8'h10, 8'h02, 8'h11};
    send_tx();
    k = 0;
    while (k < 150) begin
      @(negedge clk);
      k++;
      if (frame_err === 1'b1) break;
    end
    exp_err_count++;
    checks++;
    if (k != 100) begin
      errors++;
      $display("FAIL tmo_latency: frameErr after %0d cycles, required 100", k);
    end
    checks++;
    if (err_code !== 3'd4 || state !== 3'd0) begin
      errors++;
      $display("FAIL tmo_code: code=%0d state=%0d, required 4/0", err_code, state);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (err_pulses - err0 != 1) begin
      errors++;
      $display("FAIL tmo_pulse: %0d pulse cycles, required 1", err_pulses - err0);
    end
    tmo_cycles = '0;
  endtask

  task automatic test_line_error();
    int err0;
    err0 = err_pulses;
    wr_q.delete();
    tx_q = '{8'hA5, 8'h10, 8'h02};
    send_tx();
    send_char(11'h211);
    send_char(11'h022);
    send_char(11'h4A5);
    @(negedge clk);
    exp_err_count++;
    checks++;
    if (err_code !== 3'd3 || err_pulses - err0 != 1) begin
      errors++;
      $display("FAIL line_code: code=%0d pulses=%0d, required 3/1", err_code, err_pulses - err0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL line_hunt: busy=%b after flagged A5 in hunt, required 0", busy);
    end
    exp_q = '{16'h5077};
    tx_q = '{8'hA5, 8'h50, 8'h01, 8'h77, 8'h26};
    send_tx();
    wait_idle();
    checks++;
    if (wr_q.size() != 1 || wr_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL line_recover: %0d writes, first %h, required 1 write 5077", wr_q.size(),
               (wr_q.size() > 0) ? wr_q[0] : 16'h0);
    end
    checks++;
    if (err_count !== 8'(exp_err_count)) begin
      errors++;
      $display("FAIL line_errcount: %0d, required %0d", err_count, exp_err_count);
    end
  endtask

  task automatic test_back_to_back();
    int ok0;
    ok0 = ok_pulses;
    wr_q.delete();
    exp_q = '{16'h30A5, 16'h405A};
    tx_q = '{8'hA5, 8'h30, 8'h01, 8'hA5, 8'h94, 8'hA5, 8'h40, 8'h01, 8'h5A, 8'h1B};
    send_tx();
    wait_idle();
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count: %0d writes, required %0d", wr_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (wr_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL b2b_write%0d: addr/data %h, required %h", i, wr_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (ok_pulses - ok0 != 2) begin
      errors++;
      $display("FAIL b2b_ok: %0d pulse cycles, required 2", ok_pulses - ok0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int ok0, err0;
    err0 = err_pulses;
    tx_q = '{8'hA5, 8'h10, 8'h03, 8'h11};
    send_tx();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy: busy=%b mid-frame, required 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_err_count = 0;
    checks++;
    if (busy !== 1'b0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL midrst_state: busy=%b count=%0d, required 0/0", busy, err_count);
    end
    ok0 = ok_pulses;
    wr_q.delete();
    ack_delay = 40;
    tx_q = '{8'hA5, 8'h60, 8'h01, 8'h33, 8'h52};
    send_tx();
    repeat (3) @(negedge clk);
    checks++;
    if (wr_req !== 1'b1) begin
      errors++;
      $display("FAIL emitrst_pending: regWriteReq=%b, required 1", wr_req);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (wr_req !== 1'b0 || state !== 3'd0) begin
      errors++;
      $display("FAIL emitrst_drop: regWriteReq=%b state=%0d, required 0/0", wr_req, state);
    end
    repeat (3) @(negedge clk);
    ack_delay = 0;
    checks++;
    if (ok_pulses != ok0 || err_pulses != err0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL emitrst_quiet: ok=%0d err=%0d writes=%0d, required 0/0/0",
               ok_pulses - ok0, err_pulses - err0, wr_q.size());
    end
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 300; i++) begin
      tx_q = '{8'hA5, 8'h00, 8'h00};
      send_tx();
      if (i == 200) begin
        checks++;
        if (err_count !== 8'd200) begin
          errors++;
          $display("FAIL sat_mid: errCount=%0d, required 200", err_count);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (err_count !== 8'd255 || err_code !== 3'd1) begin
      errors++;
      $display("FAIL sat_final: errCount=%0d code=%0d, required 255/1", err_count, err_code);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_noise_wrap_stall();
    test_len_limits();
    test_timeout();
    test_line_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
